// File: rtl/clk_div_ctrl.sv
// -----------------------------------------------------------------------------
// clk_div_ctrl
//   Sequences ratio changes for the programmable clock divider so that a new
//   ratio is never applied while the divider is running. An accepted request
//   gates the divider off, waits a guard interval, loads the ratio, waits a
//   settle interval and then re-enables (or stays off, per i_enable).
//   Also owns the run/stop state of the divided clock.
//
// Ports
//   i_ref_clk    reference clock (same clock as the divider)
//   i_rst        asynchronous reset, active low
//   i_enable     level request to run the divided clock
//   i_cfg_valid  ratio-change request valid
//   i_cfg_ratio  requested ratio
//   o_cfg_ready  request can be accepted (OFF / RUN only)
//   o_cfg_err    one-cycle pulse: request rejected (ratio 0 or 1)
//   o_done       one-cycle pulse: ratio change complete
//   o_busy       high while a change sequence is in progress
//   o_div_en     divider clock enable
//   o_div_ratio  divider ratio
// -----------------------------------------------------------------------------
module clk_div_ctrl #(
  parameter int RATIO_WIDTH   = 8,
  parameter int RESET_RATIO   = 2,
  parameter int GUARD_CYCLES  = 4,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                   i_ref_clk,
  input  logic                   i_rst,
  input  logic                   i_enable,
  input  logic                   i_cfg_valid,
  input  logic [RATIO_WIDTH-1:0] i_cfg_ratio,
  output logic                   o_cfg_ready,
  output logic                   o_cfg_err,
  output logic                   o_done,
  output logic                   o_busy,
  output logic                   o_div_en,
  output logic [RATIO_WIDTH-1:0] o_div_ratio
);

  typedef enum logic [2:0] {
    OFF    = 3'd0,
    RUN    = 3'd1,
    STOP   = 3'd2,
    LOAD   = 3'd3,
    SETTLE = 3'd4
  } state_t;

  localparam logic [7:0]             GUARD_LAST  = 8'(GUARD_CYCLES - 1);
  localparam logic [7:0]             SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
  localparam logic [RATIO_WIDTH-1:0] RATIO_RST   = RATIO_WIDTH'(RESET_RATIO);
  localparam logic [RATIO_WIDTH-1:0] RATIO_MIN   = RATIO_WIDTH'(2);

  state_t                 state;
  logic [7:0]             cnt;
  logic [RATIO_WIDTH-1:0] pending;

  always_ff @(posedge i_ref_clk or negedge i_rst) begin
    if (!i_rst) begin
      state       <= OFF;
      cnt         <= 8'd0;
      pending     <= '0;
      o_div_ratio <= RATIO_RST;
      o_div_en    <= 1'b0;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
      o_cfg_err   <= 1'b0;
      o_cfg_ready <= 1'b1;
    end else begin
      // Pulses default low; each is raised for exactly one cycle below.
      o_done    <= 1'b0;
      o_cfg_err <= 1'b0;

      case (state)
        OFF, RUN: begin
          // A request (even a rejected one) takes priority over i_enable.
          if (i_cfg_valid && o_cfg_ready) begin
            if (i_cfg_ratio < RATIO_MIN) begin
              o_cfg_err <= 1'b1;
            end else begin
              pending     <= i_cfg_ratio;
              cnt         <= 8'd0;
              o_busy      <= 1'b1;
              o_cfg_ready <= 1'b0;
              o_div_en    <= 1'b0;
              // From OFF the divider is already stopped, so skip the guard.
              state       <= (state == RUN) ? STOP : LOAD;
            end
          end else if (state == OFF && i_enable) begin
            state    <= RUN;
            cnt      <= 8'd0;
            o_div_en <= 1'b1;
          end else if (state == RUN && !i_enable) begin
            state    <= OFF;
            cnt      <= 8'd0;
            o_div_en <= 1'b0;
          end
        end

        STOP: begin
          if (cnt == GUARD_LAST) begin
            state <= LOAD;
            cnt   <= 8'd0;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end

        LOAD: begin
          o_div_ratio <= pending;
          state       <= SETTLE;
          cnt         <= 8'd0;
        end

        SETTLE: begin
          if (cnt == SETTLE_LAST) begin
            cnt         <= 8'd0;
            o_done      <= 1'b1;
            o_busy      <= 1'b0;
            o_cfg_ready <= 1'b1;
            // i_enable is only looked at here while a change is in flight.
            if (i_enable) begin
              state    <= RUN;
              o_div_en <= 1'b1;
            end else begin
              state    <= OFF;
              o_div_en <= 1'b0;
            end
          end else begin
            cnt <= cnt + 8'd1;
          end
        end

        default: begin
          state       <= OFF;
          cnt         <= 8'd0;
          o_div_en    <= 1'b0;
          o_busy      <= 1'b0;
          o_cfg_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
